fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the team's dual-clock FIFO, operating entirely in the read clock domain. It owns the read pointer and drives the read address into the FIFO memory, whose read port is asynchronous. It computes empty, level and almost-empty against the synchronized write pointer and prefetches memory data into a registered valid/ready output stage. Its Gray read pointer is exported to the write domain through the existing 2-FF synchronizer.

Parameters:
DATASIZE, 8, data word width (matches the FIFO memory).
ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE.
AE_LEVEL, 2, ralmost_empty asserts when unfetched entries <= AE_LEVEL.

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  reset, synchronous, active-low
rq2_wptr  input  ADDRSIZE+1  Gray write pointer, already synchronized into rclk
rdata  input  DATASIZE  combinational read data from memory at raddr
raddr  output  ADDRSIZE  memory read address
rptr  output  ADDRSIZE+1  registered Gray read pointer, to the write domain
rempty  output  1  memory holds no unfetched entry (registered)
rlevel  output  ADDRSIZE+1  unfetched entries in memory, 0..2^ADDRSIZE (registered)
ralmost_empty  output  1  registered, rlevel <= AE_LEVEL
dout  output  DATASIZE  output data register
dout_valid  output  1  dout holds a word
dout_ready  input  1  consumer accepts dout this cycle

Behaviour:
- Reset: on a rclk edge with rrst_n=0, clear all state. rbin=0, rptr=0, raddr=0, rempty=1, rlevel=0, ralmost_empty=1, dout=0, dout_valid=0. A mid-operation reset discards any held word; the write side is reset in the same system reset.
- State:
  - rbin is an ADDRSIZE+1-bit binary pointer that wraps modulo 2^(ADDRSIZE+1).
  - rptr = bin2gray(rbin), held as a register, never combinational.
  - raddr = rbin[ADDRSIZE-1:0].
- fetch = !rempty && (!dout_valid || dout_ready). This is the only event that reads memory.
- On fetch:
  - dout <= rdata and dout_valid <= 1.
  - rbin_next = rbin+1; rptr <= bin2gray(rbin_next).
- On no fetch with dout_valid && dout_ready: dout_valid <= 0. dout keeps its old value.
- Otherwise dout and dout_valid hold. dout must be stable while dout_valid=1 and dout_ready=0.
- Status flags, registered and computed on next-state values:
  - rempty <= (bin2gray(rbin_next) == rq2_wptr).
  - rlevel <= gray2bin(rq2_wptr) - rbin_next, computed modulo 2^(ADDRSIZE+1). The MSB difference makes a full memory read as 2^ADDRSIZE.
  - ralmost_empty <= (that level <= AE_LEVEL).
- Latency:
  - A change in rq2_wptr at cycle N deasserts rempty at edge N+1.
  - The first fetch occurs at edge N+2, so dout_valid is high after edge N+2.
- Throughput: one word per cycle when dout_ready is held at 1 and data is available.
- Simultaneous consume and fetch on one edge: dout is replaced, dout_valid stays 1, and no bubble is inserted.
- Underflow is impossible because fetch is gated by rempty. A full memory needs no read-side handling.
- Pointer wrap: crossing 2^ADDRSIZE toggles the rbin MSB and raddr returns to 0. Crossing 2^(ADDRSIZE+1) returns rbin to 0. Gray conversion is continuous across both.
- rq2_wptr may advance by several entries between samples. rlevel and rempty must remain correct for any legal value.

Decomposition:
- fifo_pkg holds the bin2gray and gray2bin functions (parameterized by width) and a PTRW = ADDRSIZE+1 helper constant. These are shared with the write-side controller.
- No sub-module. The output stage is a handful of registers and stays inline.

Test Plan (DATASIZE=8, ADDRSIZE=4, AE_LEVEL=2):
1. Reset:
   - Stimulus: rrst_n=0 for 2 edges, then 1; rq2_wptr=00000.
   - Required: rempty=1, rlevel=0, ralmost_empty=1, dout_valid=0, raddr=0, rptr=00000.
2. Single word held by backpressure:
   - Stimulus: mem[0]=8'hA5, rq2_wptr=00001, dout_ready=0.
   - Edge 1: rempty=0, rlevel=1.
   - Edge 2: dout=A5, dout_valid=1, raddr=1, rptr=00001, rempty=1, rlevel=0.
   - dout and dout_valid hold for 5 further cycles.
3. Streaming:
   - Stimulus: mem[0..3]=10,11,12,13, rq2_wptr=gray(4)=00110, dout_ready=1.
   - Required: dout shows 10,11,12,13 on 4 consecutive cycles with dout_valid=1, then dout_valid=0 and rempty=1.
   - ralmost_empty goes 0 to 1 once rlevel reaches 2.
4. Full memory:
   - Stimulus: rq2_wptr=gray(16)=11000, dout_ready=0.
   - After edge 1: rlevel=16, ralmost_empty=0.
   - After the first fetch: rlevel=15, and no further fetch until dout_ready=1.
5. Wrap-around:
   - Stimulus: stream 17 words with dout_ready=1 across the MSB toggle.
   - Required: raddr sequence 0..15,0; final rbin=17, rptr=11001, rempty=1.
   - Every dout equals the written data.
6. Mid-stream reset:
   - Stimulus: dout_valid=1, rlevel=5, dout_ready=0; pull rrst_n=0 for one edge.
   - Required: all outputs at reset values after that edge; normal operation resumes with rbin=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO controllers.
// Gray/binary conversions are written on a 32-bit carrier; callers
// zero-extend their pointer, convert, and truncate back to pointer width.
// Zero-extension is harmless for both directions because the leading
// zero bits contribute nothing to the XOR chains.
package fifo_pkg;

    // Default address width of the FIFO and the matching pointer width.
    localparam int ADDRSIZE_DEFAULT = 4;
    localparam int PTRW             = ADDRSIZE_DEFAULT + 1;

    // Pointer width for a given address width: one extra bit distinguishes
    // a full memory from an empty one.
    function automatic int ptrw(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (read clock domain only).
// Owns the read pointer, addresses the asynchronous-read memory, derives
// empty/level/almost-empty from the synchronized write pointer, and
// prefetches one word into a registered valid/ready output stage.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDRSIZE:0]     rq2_wptr,
    input  logic [DATASIZE-1:0]   rdata,
    output logic [ADDRSIZE-1:0]   raddr,
    output logic [ADDRSIZE:0]     rptr,
    output logic                  rempty,
    output logic [ADDRSIZE:0]     rlevel,
    output logic                  ralmost_empty,
    output logic [DATASIZE-1:0]   dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int             PW     = ptrw(ADDRSIZE);
    localparam logic [PW-1:0]  AE_THR = PW'(AE_LEVEL);

    logic [PW-1:0]       rbin_q, rbin_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [PW-1:0]       rlevel_q, rlevel_d;
    logic [PW-1:0]       wbin;
    logic                rempty_q, rempty_d;
    logic                ralmost_empty_q, ralmost_empty_d;
    logic [DATASIZE-1:0] dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                fetch;

    // Pointer advance and status flags, all evaluated on the post-fetch pointer
    // so the registered flags describe the memory as it will be next cycle.
    always_comb begin
        fetch           = !rempty_q && (!dout_valid_q || dout_ready);
        rbin_d          = rbin_q + {{(PW-1){1'b0}}, fetch};
        rptr_d          = PW'(bin2gray(32'(rbin_d)));
        wbin            = PW'(gray2bin(32'(rq2_wptr)));
        // Modulo-2^PW difference: a full memory reads as 2^ADDRSIZE.
        rlevel_d        = wbin - rbin_d;
        rempty_d        = (rptr_d == rq2_wptr);
        ralmost_empty_d = (rlevel_d <= AE_THR);
    end

    // Output stage: load on fetch, drop valid on a consume with nothing new,
    // otherwise hold so dout is stable under backpressure.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (fetch) begin
            dout_d       = rdata;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rlevel_q        <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rlevel_q        <= rlevel_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
        end
    end

    assign raddr         = rbin_q[ADDRSIZE-1:0];
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_empty_q;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: models the FIFO memory and write side, checks
// flags against hand-derived vectors and data via a scoreboard queue.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic [4:0] rq2_wptr;
    logic [7:0] rdata;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [4:0] rlevel;
    logic       ralmost_empty;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] mem [16];
    logic [4:0] wcnt;
    logic [7:0] sb [$];
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_dout;
        logic       exp_rempty;
        logic [4:0] exp_level;
        logic       exp_ae;
    } vec_t;
    vec_t tbl [6];

    fifo_rd_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .AE_LEVEL(2)) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rq2_wptr      (rq2_wptr),
        .rdata         (rdata),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready)
    );

    always #5 rclk = ~rclk;

    // Asynchronous memory read port.
    assign rdata = mem[raddr];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wcnt[3:0]] = d;
        sb.push_back(d);
        wcnt = wcnt + 5'd1;
    endtask

    task automatic do_reset();
        rrst_n     = 1'b0;
        rq2_wptr   = 5'd0;
        dout_ready = 1'b0;
        tick();
        rrst_n = 1'b1;
        sb.delete();
        wcnt = 5'd0;
    endtask

    // Scoreboard consumer: a transfer happens on the coming edge whenever
    // dout_valid && dout_ready are both high mid-cycle.
    always @(negedge rclk) begin
        if (rrst_n === 1'b1 && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                $display("xfer dout=%02h expected=%02h", dout, e);
                chk("sb_data", 32'(dout), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Streaming vectors after four words are published with ready held high.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd4, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h10, 1'b0, 5'd3, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b0, 5'd2, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h12, 1'b0, 5'd1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h13, 1'b1, 5'd0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        wcnt       = 5'd0;
        rrst_n     = 1'b0;
        rq2_wptr   = 5'd0;
        dout_ready = 1'b0;

        // 1. Reset
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_rlevel", 32'(rlevel), 32'd0);
        chk("rst_ae",     32'(ralmost_empty), 32'd1);
        chk("rst_valid",  32'(dout_valid), 32'd0);
        chk("rst_raddr",  32'(raddr), 32'd0);
        chk("rst_rptr",   32'(rptr), 32'd0);
        $display("txn reset done");

        // 2. Single word held by backpressure
        push_word(8'hA5);
        rq2_wptr = gray(wcnt);
        tick();
        chk("one_e1_rempty", 32'(rempty), 32'd0);
        chk("one_e1_rlevel", 32'(rlevel), 32'd1);
        chk("one_e1_valid",  32'(dout_valid), 32'd0);
        tick();
        chk("one_e2_dout",   32'(dout), 32'hA5);
        chk("one_e2_valid",  32'(dout_valid), 32'd1);
        chk("one_e2_raddr",  32'(raddr), 32'd1);
        chk("one_e2_rptr",   32'(rptr), 32'h01);
        chk("one_e2_rempty", 32'(rempty), 32'd1);
        chk("one_e2_rlevel", 32'(rlevel), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_dout",  32'(dout), 32'hA5);
            chk("hold_valid", 32'(dout_valid), 32'd1);
        end
        dout_ready = 1'b1;
        tick();
        chk("one_drain_valid", 32'(dout_valid), 32'd0);
        chk("one_drain_sb",    32'(sb.size()), 32'd0);

        // 3. Streaming, table-driven
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
        rq2_wptr = gray(wcnt);
        for (int i = 0; i < 6; i++) begin
            dout_ready = tbl[i].ready;
            tick();
            $display("txn stream step %0d valid=%0b dout=%02h level=%0d", i, dout_valid, dout, rlevel);
            chk("stream_valid",  32'(dout_valid), 32'(tbl[i].exp_valid));
            chk("stream_rempty", 32'(rempty), 32'(tbl[i].exp_rempty));
            chk("stream_rlevel", 32'(rlevel), 32'(tbl[i].exp_level));
            chk("stream_ae",     32'(ralmost_empty), 32'(tbl[i].exp_ae));
            if (tbl[i].exp_valid) chk("stream_dout", 32'(dout), 32'(tbl[i].exp_dout));
        end
        chk("stream_sb", 32'(sb.size()), 32'd0);

        // 4. Full memory under backpressure
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'h40 + 8'(i));
        rq2_wptr = gray(wcnt);
        tick();
        chk("full_e1_rlevel", 32'(rlevel), 32'd16);
        chk("full_e1_ae",     32'(ralmost_empty), 32'd0);
        chk("full_e1_rempty", 32'(rempty), 32'd0);
        tick();
        chk("full_e2_rlevel", 32'(rlevel), 32'd15);
        chk("full_e2_dout",   32'(dout), 32'h40);
        chk("full_e2_valid",  32'(dout_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold_rlevel", 32'(rlevel), 32'd15);
            chk("full_hold_raddr",  32'(raddr), 32'd1);
            chk("full_hold_dout",   32'(dout), 32'h40);
        end

        // 5. Wrap-around: a 17th word lands in slot 0 once it has been fetched
        push_word(8'h50);
        rq2_wptr   = gray(wcnt);
        dout_ready = 1'b1;
        tick();
        chk("wrap_refill_rlevel", 32'(rlevel), 32'd15);
        n = 0;
        while ((sb.size() != 0 || dout_valid) && n < 40) begin
            tick();
            n++;
        end
        chk("wrap_drain_budget", 32'(n < 40), 32'd1);
        chk("wrap_sb",     32'(sb.size()), 32'd0);
        chk("wrap_raddr",  32'(raddr), 32'd1);
        chk("wrap_rptr",   32'(rptr), 32'b11001);
        chk("wrap_rempty", 32'(rempty), 32'd1);
        chk("wrap_rlevel", 32'(rlevel), 32'd0);

        // 6. Mid-stream reset with a held word
        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'h60 + 8'(i));
        rq2_wptr = gray(wcnt);
        tick();
        chk("mid_e1_rlevel", 32'(rlevel), 32'd6);
        tick();
        chk("mid_e2_rlevel", 32'(rlevel), 32'd5);
        chk("mid_e2_valid",  32'(dout_valid), 32'd1);
        chk("mid_e2_dout",   32'(dout), 32'h60);
        rrst_n   = 1'b0;
        rq2_wptr = 5'd0;
        tick();
        chk("mid_rst_rempty", 32'(rempty), 32'd1);
        chk("mid_rst_rlevel", 32'(rlevel), 32'd0);
        chk("mid_rst_ae",     32'(ralmost_empty), 32'd1);
        chk("mid_rst_valid",  32'(dout_valid), 32'd0);
        chk("mid_rst_dout",   32'(dout), 32'd0);
        chk("mid_rst_raddr",  32'(raddr), 32'd0);
        chk("mid_rst_rptr",   32'(rptr), 32'd0);
        rrst_n = 1'b1;
        sb.delete();
        wcnt = 5'd0;
        push_word(8'h77);
        push_word(8'h78);
        rq2_wptr   = gray(wcnt);
        dout_ready = 1'b1;
        tick();
        chk("resume_e1_rempty", 32'(rempty), 32'd0);
        chk("resume_e1_rlevel", 32'(rlevel), 32'd2);
        chk("resume_e1_ae",     32'(ralmost_empty), 32'd1);
        tick();
        chk("resume_e2_dout",  32'(dout), 32'h77);
        chk("resume_e2_raddr", 32'(raddr), 32'd1);
        tick();
        chk("resume_e3_dout",  32'(dout), 32'h78);
        chk("resume_e3_raddr", 32'(raddr), 32'd2);
        chk("resume_e3_rptr",  32'(rptr), 32'b00011);
        tick();
        chk("resume_e4_valid", 32'(dout_valid), 32'd0);
        chk("resume_sb",       32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
